// File: rtl/fft_data_output.sv
// Frame capture buffer behind the FFT core: one AXIS frame of {IM, RE} beats lands in a
// word-addressed RAM (even word = RE, odd word = IM) that software reads once done fires.
module fft_data_output #(
    parameter int NFFT = 8,
    localparam int AW = $clog2(2 * NFFT),
    localparam int IW = $clog2(NFFT),
    localparam int BW = $clog2(NFFT) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          tvalid,
    output logic          tready,
    input  logic          tlast,
    input  logic [63:0]   tdata,
    input  logic [AW-1:0] rAddr,
    output logic [31:0]   rData,
    input  logic          arm,
    output logic          capturing,
    output logic          frame_valid,
    output logic          done,
    output logic          tlast_err,
    output logic [BW-1:0] beats
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] beats_q, beats_d;
    logic          frame_valid_q, frame_valid_d;
    logic          tlast_err_q, tlast_err_d;
    logic          done_q, done_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          accept;
    logic          last_slot;
    logic          arm_ok;
    logic          wr_en;
    logic [IW-1:0] wr_idx;

    // RE and IM live in separate banks so one beat writes both halves in a single cycle.
    logic [31:0]   ram_re [NFFT];
    logic [31:0]   ram_im [NFFT];

    assign accept    = tvalid && tready;
    assign last_slot = (beats_q == BW'(NFFT - 1));
    assign arm_ok    = arm && ((state_q == IDLE) || (state_q == DONE));
    assign wr_en     = accept && (state_q == CAPTURE);
    assign wr_idx    = beats_q[IW-1:0];

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (arm) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (accept) begin
                    if (tlast)          state_d = DONE;
                    else if (last_slot) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (accept && tlast) state_d = DONE;
            end
            DONE: begin
                if (arm) state_d = CAPTURE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake decoded from the state register alone so tready never depends on tvalid.
    always_comb begin
        tready    = 1'b0;
        capturing = 1'b0;
        if ((state_q == CAPTURE) || (state_q == DRAIN)) begin
            tready    = 1'b1;
            capturing = 1'b1;
        end
    end

    always_comb begin
        beats_d       = beats_q;
        frame_valid_d = frame_valid_q;
        tlast_err_d   = tlast_err_q;
        done_d        = 1'b0;

        if (arm_ok) begin
            beats_d       = '0;
            frame_valid_d = 1'b0;
            tlast_err_d   = 1'b0;
        end

        if (wr_en) begin
            beats_d = beats_q + BW'(1);
            // Either an early tlast or a missing one on the final slot is a framing error.
            if (tlast != last_slot) tlast_err_d = 1'b1;
        end

        if (accept && tlast && ((state_q == CAPTURE) || (state_q == DRAIN))) begin
            frame_valid_d = 1'b1;
            done_d        = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beats_q       <= '0;
            frame_valid_q <= 1'b0;
            tlast_err_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            beats_q       <= beats_d;
            frame_valid_q <= frame_valid_d;
            tlast_err_q   <= tlast_err_d;
            done_q        <= done_d;
        end
    end

    // NOTE: the RAM has no reset; clearing it would forbid mapping onto block RAM and
    // software never trusts its contents until frame_valid is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_re[wr_idx] <= tdata[31:0];
            ram_im[wr_idx] <= tdata[63:32];
        end
    end

    // Read returns the pre-write word when the same address is written on this edge.
    always_comb begin
        rdata_d = rAddr[0] ? ram_im[rAddr[AW-1:1]] : ram_re[rAddr[AW-1:1]];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rData       = rdata_q;
    assign frame_valid = frame_valid_q;
    assign done        = done_q;
    assign tlast_err   = tlast_err_q;
    assign beats       = beats_q;

endmodule

// File: tb/tb_fft_data_output.sv
// Bench for fft_data_output: table of frame shapes, hand sequences for arm/reset corners,
// and random frames, all checked against a word-level RAM model built from beat data.
module tb_fft_data_output;

    localparam int NFFT = 8;
    localparam int AW   = $clog2(2 * NFFT);
    localparam int BW   = $clog2(NFFT) + 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [63:0]   tdata;
    logic [AW-1:0] rAddr;
    logic [31:0]   rData;
    logic          arm;
    logic          capturing;
    logic          frame_valid;
    logic          done;
    logic          tlast_err;
    logic [BW-1:0] beats;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] model_ram   [2*NFFT];
    bit          model_known [2*NFFT];

    typedef struct {
        int tlast_at;   // beat index carrying tlast
        int vmode;      // 0: tvalid held, 1: toggling, 2: random gaps
        bit ramp;       // tdata = {k+0x100, k} instead of random
        bit arm_mid;    // stray arm pulse during the frame
        int exp_beats;
        bit exp_err;
    } frame_vec_t;

    fft_data_output #(.NFFT(NFFT)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .tvalid      (tvalid),
        .tready      (tready),
        .tlast       (tlast),
        .tdata       (tdata),
        .rAddr       (rAddr),
        .rData       (rData),
        .arm         (arm),
        .capturing   (capturing),
        .frame_valid (frame_valid),
        .done        (done),
        .tlast_err   (tlast_err),
        .beats       (beats)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("arm_tready", tready, 1);
        check("arm_capturing", capturing, 1);
        check("arm_frame_valid", frame_valid, 0);
        check("arm_beats", beats, 0);
        check("arm_tlast_err", tlast_err, 0);
        check("arm_done", done, 0);
    endtask

    // Sends beats 0..tlast_at; leaves the bench in the cycle right after the last accept.
    task automatic send_frame(input frame_vec_t v);
        logic [63:0] d;
        logic [31:0] old_word;
        bit          old_known;
        int          gaps;
        for (int b = 0; b <= v.tlast_at; b++) begin
            gaps = (v.vmode == 1 && b > 0) ? 1 : (v.vmode == 2 ? int'($urandom_range(0, 2)) : 0);
            for (int g = 0; g < gaps; g++) begin
                tvalid = 1'b0;
                tlast  = 1'b0;
                step();
                check("gap_beats", beats, imin(b, NFFT));
                check("gap_tready", tready, 1);
                check("gap_done", done, 0);
            end
            d = v.ramp ? {32'(b + 'h100), 32'(b)} : {$urandom, $urandom};
            tvalid = 1'b1;
            tdata  = d;
            tlast  = (b == v.tlast_at);
            arm    = v.arm_mid && (b == 2);
            check("beat_tready", tready, 1);
            old_known = 1'b0;
            old_word  = '0;
            if (b < NFFT) begin
                rAddr     = AW'(2 * b);
                old_word  = model_ram[2*b];
                old_known = model_known[2*b];
            end
            step();
            tvalid = 1'b0;
            tlast  = 1'b0;
            arm    = 1'b0;
            if (b < NFFT) begin
                if (old_known) check("rd_during_wr", rData, old_word);
                model_ram[2*b]     = d[31:0];
                model_ram[2*b+1]   = d[63:32];
                model_known[2*b]   = 1'b1;
                model_known[2*b+1] = 1'b1;
            end
            if (b != v.tlast_at) begin
                check("mid_beats", beats, imin(b + 1, NFFT));
                check("mid_tready", tready, 1);
                check("mid_done", done, 0);
            end
        end
        check("end_done", done, 1);
        check("end_frame_valid", frame_valid, 1);
        check("end_tready", tready, 0);
        check("end_capturing", capturing, 0);
        check("end_beats", beats, v.exp_beats);
        check("end_tlast_err", tlast_err, v.exp_err);
    endtask

    task automatic idle_after_done(input int exp_beats);
        step();
        check("post_done_low", done, 0);
        check("post_frame_valid", frame_valid, 1);
        check("post_beats", beats, exp_beats);
    endtask

    task automatic read_all();
        for (int a = 0; a < 2 * NFFT; a++) begin
            rAddr = AW'(a);
            step();
            if (model_known[a]) check($sformatf("ram[%0d]", a), rData, model_ram[a]);
        end
    endtask

    frame_vec_t vecs [6];
    frame_vec_t rv;

    initial begin
        resetn = 1'b0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
        rAddr  = '0;
        arm    = 1'b0;
        for (int a = 0; a < 2 * NFFT; a++) begin
            model_ram[a]   = '0;
            model_known[a] = 1'b0;
        end

        vecs[0] = '{tlast_at: 7,  vmode: 0, ramp: 1, arm_mid: 0, exp_beats: 8, exp_err: 0};
        vecs[1] = '{tlast_at: 7,  vmode: 1, ramp: 1, arm_mid: 1, exp_beats: 8, exp_err: 0};
        vecs[2] = '{tlast_at: 3,  vmode: 0, ramp: 0, arm_mid: 0, exp_beats: 4, exp_err: 1};
        vecs[3] = '{tlast_at: 10, vmode: 0, ramp: 0, arm_mid: 0, exp_beats: 8, exp_err: 1};
        vecs[4] = '{tlast_at: 0,  vmode: 2, ramp: 0, arm_mid: 0, exp_beats: 1, exp_err: 1};
        vecs[5] = '{tlast_at: 9,  vmode: 2, ramp: 0, arm_mid: 1, exp_beats: 8, exp_err: 1};

        #12;
        check("rst_tready", tready, 0);
        check("rst_capturing", capturing, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_done", done, 0);
        check("rst_tlast_err", tlast_err, 0);
        check("rst_beats", beats, 0);
        check("rst_rData", rData, 0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("idle_tready", tready, 0);

        for (int i = 0; i < 6; i++) begin
            arm_pulse();
            send_frame(vecs[i]);
            idle_after_done(vecs[i].exp_beats);
            read_all();
        end

        // arm coincident with done re-arms immediately and clears the previous status
        arm_pulse();
        send_frame('{tlast_at: 4, vmode: 0, ramp: 0, arm_mid: 0, exp_beats: 5, exp_err: 1});
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("rearm_frame_valid", frame_valid, 0);
        check("rearm_tready", tready, 1);
        check("rearm_done", done, 0);
        check("rearm_beats", beats, 0);
        check("rearm_tlast_err", tlast_err, 0);
        send_frame('{tlast_at: 7, vmode: 0, ramp: 0, arm_mid: 0, exp_beats: 8, exp_err: 0});
        idle_after_done(8);
        read_all();

        // reset in the middle of a frame abandons it; written words stay in RAM
        arm_pulse();
        for (int b = 0; b < 4; b++) begin
            tdata  = {$urandom, $urandom};
            tvalid = 1'b1;
            step();
            model_ram[2*b]   = tdata[31:0];
            model_ram[2*b+1] = tdata[63:32];
        end
        tvalid = 1'b0;
        check("pre_rst_beats", beats, 4);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_tready", tready, 0);
        check("mid_rst_capturing", capturing, 0);
        check("mid_rst_frame_valid", frame_valid, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_tlast_err", tlast_err, 0);
        check("mid_rst_beats", beats, 0);
        check("mid_rst_rData", rData, 0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("post_rst_tready", tready, 0);
        read_all();
        arm_pulse();
        send_frame('{tlast_at: 7, vmode: 2, ramp: 0, arm_mid: 0, exp_beats: 8, exp_err: 0});
        idle_after_done(8);
        read_all();

        // random frame shapes; expectations follow from where tlast lands
        for (int f = 0; f < 10; f++) begin
            rv.tlast_at  = int'($urandom_range(0, NFFT + 3));
            rv.vmode     = int'($urandom_range(0, 2));
            rv.ramp      = 1'b0;
            rv.arm_mid   = 1'($urandom_range(0, 1));
            rv.exp_beats = imin(rv.tlast_at + 1, NFFT);
            rv.exp_err   = (rv.tlast_at != NFFT - 1);
            arm_pulse();
            send_frame(rv);
            idle_after_done(rv.exp_beats);
            read_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
